// File: rtl/pc_unit.sv
// pc_unit: architectural program counter with next-PC selection, stall,
// trap/return path (saved exception PC) and a retired-instruction counter.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   stall               hold all state (a trap still wins)
//   br_taken/br_offset  relative branch, target = pc + br_offset
//   jmp/jmp_target      absolute jump
//   trap                synchronous exception request
//   mret                return from trap (sequential advance when not trapped)
//   pc, pc_inc          current PC and pc + STEP (link value)
//   epc                 saved exception PC
//   in_trap             FSM is in TRAPPED
//   misaligned          last trap came from a misaligned jump/branch target
//   dbl_fault           a trap was taken while already TRAPPED (sticky)
//   retired             retired-instruction count, wraps
//
// state   | meaning
// RUN     | normal execution
// TRAPPED | executing the trap handler; mret returns to epc
module pc_unit #(
  parameter int              WIDTH        = 32,
  parameter int              STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_4000,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_offset,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             trap,
  input  logic             mret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_inc,
  output logic [WIDTH-1:0] epc,
  output logic             in_trap,
  output logic             misaligned,
  output logic             dbl_fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic {RUN, TRAPPED} state_t;

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  state_t           state;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] next_pc;
  logic             redirect;
  logic             bad_target;
  logic             take_mret;
  logic             take_trap;

  assign pc_inc  = pc + WIDTH'(STEP);
  assign in_trap = (state == TRAPPED);

  always_comb begin
    target     = jmp ? jmp_target : (pc + br_offset);
    // mret outranks jump/branch in both states; in RUN it degrades to a
    // plain sequential advance, so it still suppresses the redirect.
    redirect   = !mret && (jmp || br_taken);
    bad_target = redirect && ((target & ALIGN_MASK) != '0);
    take_mret  = mret && (state == TRAPPED);
    take_trap  = trap || (!stall && bad_target);
    next_pc    = pc_inc;
    if (take_mret)
      next_pc = epc;
    else if (redirect)
      next_pc = target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_VECTOR;
      epc        <= '0;
      misaligned <= 1'b0;
      dbl_fault  <= 1'b0;
      retired    <= '0;
    end else if (take_trap) begin
      pc <= TRAP_VECTOR;
      if (state == RUN) begin
        epc        <= pc;
        misaligned <= !trap;
        state      <= TRAPPED;
      end else begin
        // Nested fault: keep the original epc so the first fault stays recoverable.
        dbl_fault <= 1'b1;
      end
    end else if (!stall) begin
      pc      <= next_pc;
      retired <= retired + CNT_W'(1);
      if (take_mret) begin
        state      <= RUN;
        misaligned <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, br_taken = 1'b0, jmp = 1'b0, trap = 1'b0, mret = 1'b0;
  logic [31:0] br_offset = '0, jmp_target = '0;
  logic [31:0] pc, pc_inc, epc, retired;
  logic        in_trap, misaligned, dbl_fault;

  logic        rst8 = 1'b1;
  logic [7:0]  zero8 = '0;
  logic [7:0]  pc8, pc_inc8, epc8;
  logic [3:0]  retired8;
  logic        in_trap8, misaligned8, dbl_fault8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
    .jmp(jmp), .jmp_target(jmp_target), .trap(trap), .mret(mret),
    .pc(pc), .pc_inc(pc_inc), .epc(epc), .in_trap(in_trap),
    .misaligned(misaligned), .dbl_fault(dbl_fault), .retired(retired)
  );

  pc_unit #(.WIDTH(8), .STEP(4), .RESET_VECTOR(8'hF8), .TRAP_VECTOR(8'h10), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst8), .stall(1'b0), .br_taken(1'b0), .br_offset(zero8),
    .jmp(1'b0), .jmp_target(zero8), .trap(1'b0), .mret(1'b0),
    .pc(pc8), .pc_inc(pc_inc8), .epc(epc8), .in_trap(in_trap8),
    .misaligned(misaligned8), .dbl_fault(dbl_fault8), .retired(retired8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; br_taken = 0; jmp = 0; trap = 0; mret = 0;
    br_offset = '0; jmp_target = '0;
  endtask

  // Called at edge+1: pulse reset well before the next edge.
  task automatic do_reset();
    idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state and free-running sequence
    tick();
    do_reset();
    chk("rst_pc", pc, 32'h4000);
    chk("rst_epc", epc, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_flags", {29'd0, in_trap, misaligned, dbl_fault}, 32'h0);
    chk("rst_pc_inc", pc_inc, 32'h4004);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("seq_pc", pc, 32'h4000 + 32'(4 * i));
      chk("seq_pc_inc", pc_inc, 32'h4004 + 32'(4 * i));
    end
    chk("seq_retired", retired, 32'd9);

    // Branch, jump, stall
    do_reset();
    tick(); tick();
    chk("pre_br_pc", pc, 32'h4008);
    br_taken = 1; br_offset = 32'hFFFF_FFF8;
    tick(); idle();
    chk("br_pc", pc, 32'h4000);
    jmp = 1; jmp_target = 32'h5000;
    tick(); idle();
    chk("jmp_pc", pc, 32'h5000);
    stall = 1; jmp = 1; jmp_target = 32'h6000; br_taken = 1; br_offset = 32'h40;
    tick(); tick(); tick(); idle();
    chk("stall_pc", pc, 32'h5000);
    chk("stall_retired", retired, 32'd4);
    chk("stall_in_trap", {31'd0, in_trap}, 32'd0);

    // Trap beats jump and stall, then mret
    do_reset();
    repeat (4) tick();
    chk("pre_trap_pc", pc, 32'h4010);
    trap = 1; jmp = 1; jmp_target = 32'h5000; stall = 1;
    tick(); idle();
    chk("trap_pc", pc, 32'h100);
    chk("trap_epc", epc, 32'h4010);
    chk("trap_in_trap", {31'd0, in_trap}, 32'd1);
    chk("trap_retired", retired, 32'd4);
    chk("trap_misaligned", {31'd0, misaligned}, 32'd0);
    mret = 1;
    tick(); idle();
    chk("mret_pc", pc, 32'h4010);
    chk("mret_in_trap", {31'd0, in_trap}, 32'd0);
    chk("mret_retired", retired, 32'd5);
    mret = 1;
    tick(); idle();
    chk("run_mret_pc", pc, 32'h4014);
    chk("run_mret_in_trap", {31'd0, in_trap}, 32'd0);

    // Misaligned jump, double fault, work in TRAPPED, return
    do_reset();
    jmp = 1; jmp_target = 32'h4002;
    tick(); idle();
    chk("mis_pc", pc, 32'h100);
    chk("mis_flag", {31'd0, misaligned}, 32'd1);
    chk("mis_epc", epc, 32'h4000);
    chk("mis_retired", retired, 32'd0);
    trap = 1;
    tick(); idle();
    chk("dbl_flag", {31'd0, dbl_fault}, 32'd1);
    chk("dbl_epc", epc, 32'h4000);
    chk("dbl_pc", pc, 32'h100);
    chk("dbl_in_trap", {31'd0, in_trap}, 32'd1);
    br_taken = 1; br_offset = 32'h8;
    tick(); idle();
    chk("trapped_br_pc", pc, 32'h108);
    chk("trapped_br_in_trap", {31'd0, in_trap}, 32'd1);
    mret = 1;
    tick(); idle();
    chk("mis_mret_pc", pc, 32'h4000);
    chk("mis_mret_flag", {31'd0, misaligned}, 32'd0);
    chk("dbl_sticky", {31'd0, dbl_fault}, 32'd1);
    chk("mis_mret_retired", retired, 32'd2);

    // 8-bit instance: wrap-around and asynchronous reset
    rst8 = 1'b0;
    chk("w8_rst_pc", {24'd0, pc8}, 32'hF8);
    tick();
    chk("w8_pc_fc", {24'd0, pc8}, 32'hFC);
    chk("w8_pc_inc_wrap", {24'd0, pc_inc8}, 32'h00);
    tick();
    chk("w8_pc_00", {24'd0, pc8}, 32'h00);
    chk("w8_retired", {28'd0, retired8}, 32'd2);
    #2 rst8 = 1'b1;
    #1;
    chk("w8_async_pc", {24'd0, pc8}, 32'hF8);
    chk("w8_async_retired", {28'd0, retired8}, 32'd0);
    rst8 = 1'b0;
    repeat (15) tick();
    chk("w8_retired_15", {28'd0, retired8}, 32'd15);
    tick();
    chk("w8_retired_wrap", {28'd0, retired8}, 32'd0);
    chk("w8_pc_16", {24'd0, pc8}, 32'h38);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle core. It replaces the fixed PC+4 adder with a registered PC, next-PC selection, stall, a trap/return path with a saved exception PC, and a retired-instruction counter. It sits between the fetch memory address port and the control/branch logic, and owns the only architectural PC register in the design.

## Interface
- `WIDTH`, 32: PC and address width in bits.
- `STEP`, 4: byte increment per instruction; power of two, at least 1.
- `RESET_VECTOR`, 32'h0000_4000: PC value loaded on reset.
- `TRAP_VECTOR`, 32'h0000_0100: PC value loaded on any trap.
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold the PC and counter this cycle.
- `br_taken`  in  1  take the relative branch.
- `br_offset`  in  WIDTH  signed byte offset, added to `pc`.
- `jmp`  in  1  take the absolute jump.
- `jmp_target`  in  WIDTH  absolute byte address.
- `trap`  in  1  synchronous exception request.
- `mret`  in  1  return from trap.
- `pc`  out  WIDTH  current PC (registered).
- `pc_inc`  out  WIDTH  `pc + STEP`, combinational, modulo 2^WIDTH (link value).
- `epc`  out  WIDTH  saved exception PC (registered).
- `in_trap`  out  1  FSM is in state TRAPPED.
- `misaligned`  out  1  sticky flag: the last trap came from a misaligned target.
- `dbl_fault`  out  1  sticky flag: a trap occurred while already in TRAPPED.
- `retired`  out  CNT_W  count of retired instructions; wraps.

## Operation
- Reset: `pc` = RESET_VECTOR; `epc` = 0; `retired` = 0. `in_trap`, `misaligned` and `dbl_fault` are 0. The FSM enters RUN.
- Branch target is `pc + br_offset`, modulo 2^WIDTH. Jump target is `jmp_target`.
- A target is misaligned when any of its low log2(STEP) bits is set. Only the selected target is checked.
- Next-PC priority, highest first: `trap`, then `mret`, then `jmp`, then `br_taken`, then sequential (`pc_inc`).
- `stall` = 1 with `trap` = 0: `pc`, `epc`, the FSM state and `retired` all hold, and all other requests are ignored.
  - `trap` always overrides `stall`.
- RUN state:
  - `trap`: `pc` ← TRAP_VECTOR, `epc` ← `pc`, go to TRAPPED. `misaligned` ← 0.
  - Selected jump or branch target misaligned: same as `trap`, except `misaligned` ← 1.
  - `mret`: ignored; treated as a sequential advance.
  - Otherwise: `pc` ← selected next PC.
- TRAPPED state:
  - `mret`: `pc` ← `epc`, go to RUN. `misaligned` ← 0.
  - `trap` or misaligned target: `pc` ← TRAP_VECTOR, `epc` unchanged, `dbl_fault` ← 1, stay in TRAPPED.
  - Otherwise: normal next-PC selection; stay in TRAPPED.
- `dbl_fault` clears only on reset.
- `retired` increments by 1 on every non-stalled cycle that does not take a trap, including `mret` cycles. It wraps from all-ones to 0.

## Timing
- Every registered output updates at the rising edge that follows the sampled inputs.
- Latency from a redirect request to the new `pc` is 1 cycle. No handshake is required: the request is a level, sampled each edge.
- `pc_inc` follows `pc` combinationally within the same cycle.
- Wrap-around: `pc` = 2^WIDTH−STEP advances sequentially to 0, with no flag raised.
- Simultaneous `trap`, `jmp` and `br_taken`: the trap wins. `epc` saves the current `pc`, not the jump target.
- `rst` asserted mid-cycle clears all state immediately, without waiting for a clock edge. After `rst` deasserts, the first edge advances from RESET_VECTOR.

## Test plan
- Reset, then 9 free-running cycles: `pc` = 0x4000, 0x4004, …, 0x4024; `retired` = 9; `pc_inc` is always `pc` + 4.
- At `pc` = 0x4008, `br_taken` = 1 with `br_offset` = −8 → `pc` = 0x4000. Next cycle, `jmp` = 1 with `jmp_target` = 0x5000 → `pc` = 0x5000. Then `stall` for 3 cycles → `pc` and `retired` unchanged.
- At `pc` = 0x4010, assert `trap` together with `jmp` and `stall` → `pc` = 0x100, `epc` = 0x4010, `in_trap` = 1, `retired` unchanged. Then `mret` → `pc` = 0x4010, `in_trap` = 0.
- At `pc` = 0x4000, `jmp` = 1 with `jmp_target` = 0x4002 → `pc` = 0x100, `misaligned` = 1, `epc` = 0x4000. A second `trap` while in TRAPPED → `dbl_fault` = 1, `epc` still 0x4000.
- WIDTH = 8, STEP = 4, RESET_VECTOR = 0xF8 → sequence 0xF8, 0xFC, 0x00. Assert `rst` asynchronously between edges → `pc` = 0xF8 immediately.
